// File: rtl/ncc_frame_accumulator.sv
// rtl/ncc_frame_accumulator.sv - frame-level sum accumulator for NCC template matching
//
// Purpose: accepts one image line and the matching line of every template per
// valid/ready handshake. After NUM_OF_LINES accepted lines it presents the frame
// sums SUM(I), SUM(I^2) and SUM(T*I) per template until the consumer takes them.
//
// Ports:
//   CLK                          clock, all state on the rising edge
//   reset                        asynchronous active-high reset
//   clear                        synchronous frame abort, beats every handshake
//   in_valid / in_ready          line input handshake
//   I_in_line                    image line, LINE_SIZE unsigned pixels
//   T_in_line                    template lines, one per template channel
//   out_valid / out_ready        frame sum output handshake
//   Acc_lines_sum_I              SUM(I) over the frame
//   Acc_lines_sum_I_square       SUM(I^2) over the frame
//   Acc_lines_sum_T_x_I_out_top  SUM(T*I) per template
//   line_count                   lines accepted in the current frame
module ncc_frame_accumulator #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 8,
    parameter int NUM_OF_LINES  = 8,
    parameter int NUM_TEMPLATES = 4,
    localparam int LINE_W       = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
    localparam int ACC_W        = $clog2(NUM_OF_LINES) + LINE_W,
    localparam int CNT_W        = $clog2(NUM_OF_LINES + 1)
) (
    input  logic                                                    CLK,
    input  logic                                                    reset,
    input  logic                                                    clear,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                    I_in_line,
    input  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][PIXEL_SIZE-1:0] T_in_line,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [ACC_W-1:0]                                        Acc_lines_sum_I,
    output logic [ACC_W-1:0]                                        Acc_lines_sum_I_square,
    output logic [NUM_TEMPLATES-1:0][ACC_W-1:0]                     Acc_lines_sum_T_x_I_out_top,
    output logic [CNT_W-1:0]                                        line_count
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                               state_q;
    logic [CNT_W-1:0]                     line_count_q;
    logic                                 s1_valid_q;
    logic                                 out_valid_q;

    logic [LINE_W-1:0]                    s1_i_q, s1_i_d;
    logic [LINE_W-1:0]                    s1_i2_q, s1_i2_d;
    logic [NUM_TEMPLATES-1:0][LINE_W-1:0] s1_ti_q, s1_ti_d;

    logic [ACC_W-1:0]                     acc_i_q, acc_i_d;
    logic [ACC_W-1:0]                     acc_i2_q, acc_i2_d;
    logic [NUM_TEMPLATES-1:0][ACC_W-1:0]  acc_ti_q, acc_ti_d;

    logic                                 accept;

    // in_ready is forced low while reset is held so nothing is taken during reset.
    assign in_ready = ~reset && (state_q == ACCUM) && (line_count_q < CNT_W'(NUM_OF_LINES));
    assign accept   = in_valid && in_ready;

    // Stage 1 inputs: per-line sums. LINE_W holds LINE_SIZE products of two
    // full-scale pixels, so these never wrap.
    always_comb begin
        s1_i_d  = '0;
        s1_i2_d = '0;
        s1_ti_d = '0;
        for (int p = 0; p < LINE_SIZE; p++) begin
            s1_i_d  = s1_i_d + LINE_W'(I_in_line[p]);
            s1_i2_d = s1_i2_d + LINE_W'(I_in_line[p]) * LINE_W'(I_in_line[p]);
            for (int t = 0; t < NUM_TEMPLATES; t++) begin
                s1_ti_d[t] = s1_ti_d[t] + LINE_W'(T_in_line[t][p]) * LINE_W'(I_in_line[p]);
            end
        end
    end

    // Stage 2 inputs: running frame sums plus the registered line sums.
    always_comb begin
        acc_i_d  = acc_i_q + ACC_W'(s1_i_q);
        acc_i2_d = acc_i2_q + ACC_W'(s1_i2_q);
        acc_ti_d = '0;
        for (int t = 0; t < NUM_TEMPLATES; t++) begin
            acc_ti_d[t] = acc_ti_q[t] + ACC_W'(s1_ti_q[t]);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= ACCUM;
            line_count_q <= '0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            s1_i_q       <= '0;
            s1_i2_q      <= '0;
            s1_ti_q      <= '0;
            acc_i_q      <= '0;
            acc_i2_q     <= '0;
            acc_ti_q     <= '0;
        end else if (clear) begin
            // Abort drops any line accepted this cycle and any line still in stage 1.
            state_q      <= ACCUM;
            line_count_q <= '0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_i_q      <= '0;
            acc_i2_q     <= '0;
            acc_ti_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_i_q       <= s1_i_d;
                s1_i2_q      <= s1_i2_d;
                s1_ti_q      <= s1_ti_d;
                line_count_q <= line_count_q + CNT_W'(1);
            end
            if (s1_valid_q) begin
                acc_i_q  <= acc_i_d;
                acc_i2_q <= acc_i2_d;
                acc_ti_q <= acc_ti_d;
            end

            case (state_q)
                ACCUM: begin
                    if (accept && (line_count_q == CNT_W'(NUM_OF_LINES - 1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last line's add happened on the edge that cleared s1_valid;
                    // the sums are final now, so publish them.
                    if (!s1_valid_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q      <= ACCUM;
                        out_valid_q  <= 1'b0;
                        line_count_q <= '0;
                        s1_valid_q   <= 1'b0;
                        acc_i_q      <= '0;
                        acc_i2_q     <= '0;
                        acc_ti_q     <= '0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid                   = out_valid_q;
    assign Acc_lines_sum_I             = acc_i_q;
    assign Acc_lines_sum_I_square      = acc_i2_q;
    assign Acc_lines_sum_T_x_I_out_top = acc_ti_q;
    assign line_count                  = line_count_q;

endmodule
